// File: rtl/mcmem_responder.sv
// mcmem_responder: CPU memory responder with a word RAM, memory-mapped LED,
// TIMER and STATUS registers, and a byte-stream program loader.
// Ports:
//   i_clock, i_reset       : clock, synchronous active-high reset
//   i_madr, i_tomem        : CPU byte address (bits [1:0] ignored), write data
//   i_wmem, o_frommem      : CPU write strobe, combinational read data
//   i_ld_start, i_ld_valid : loader start pulse, byte valid
//   i_ld_data, i_ld_last   : loader byte (MSB-first in word), final-byte flag
//   o_ld_ready             : loader byte may transfer
//   o_cpu_hold             : CPU held in reset while a load is in progress
//   o_load_done            : one-cycle pulse when a load completes
//   o_led, o_bus_err       : LED register, pulse after an unmapped write
module mcmem_responder #(
   parameter int RAM_WORDS = 256
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [31:0] i_madr,
   input  logic [31:0] i_tomem,
   input  logic        i_wmem,
   output logic [31:0] o_frommem,
   input  logic        i_ld_start,
   input  logic        i_ld_valid,
   input  logic [7:0]  i_ld_data,
   input  logic        i_ld_last,
   output logic        o_ld_ready,
   output logic        o_cpu_hold,
   output logic        o_load_done,
   output logic [15:0] o_led,
   output logic        o_bus_err
);

   localparam int AW = $clog2(RAM_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_next;

   logic [31:0]   r_ram [RAM_WORDS];
   logic [AW-1:0] r_ptr;
   logic [1:0]    r_bcnt;
   logic [31:0]   r_word;
   logic          r_last;
   logic [31:0]   r_timer;
   logic          r_ovf;
   logic [15:0]   r_led;
   logic          r_bus_err;

   logic          w_is_ram;
   logic          w_is_led;
   logic          w_is_tmr;
   logic          w_is_sts;
   logic [AW-1:0] w_ram_idx;
   logic          w_cpu_we;
   logic          w_xfer;
   logic          w_tmr_wr;
   logic          w_wrap;
   logic [31:0]   w_shift;
   logic [31:0]   w_word_nx;
   logic          w_unused;

   assign w_unused  = ^i_madr[1:0];

   assign w_is_ram  = (i_madr[31:AW+2] == '0);
   assign w_ram_idx = i_madr[AW+1:2];
   assign w_is_led  = (i_madr[31:2] == 30'h3FFF_FFC0);
   assign w_is_tmr  = (i_madr[31:2] == 30'h3FFF_FFC1);
   assign w_is_sts  = (i_madr[31:2] == 30'h3FFF_FFC2);

   assign w_cpu_we  = i_wmem & ~o_cpu_hold;
   assign w_xfer    = i_ld_valid & o_ld_ready;
   assign w_tmr_wr  = w_cpu_we & w_is_tmr;
   // Wrap only counts when the increment really happens.
   assign w_wrap    = ~w_tmr_wr & (&r_timer);

   assign w_shift   = {r_word[23:0], i_ld_data};
   // A final short word is pushed up so its bytes are left-justified.
   assign w_word_nx = i_ld_last ? (w_shift << {~r_bcnt, 3'b000})
                                : w_shift;

   // Loader FSM: state register
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Loader FSM: next state
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (i_ld_start) w_next = S_LOAD;
         S_LOAD:  if (w_xfer && (r_bcnt == 2'd3 || i_ld_last))
                     w_next = S_WRITE;
         S_WRITE: w_next = r_last ? S_DONE : S_LOAD;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Loader FSM: outputs
   always_comb begin
      o_ld_ready  = (r_state == S_LOAD);
      o_cpu_hold  = (r_state != S_IDLE);
      o_load_done = (r_state == S_DONE);
   end

   // Loader datapath
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_ptr  <= '0;
         r_bcnt <= '0;
         r_word <= '0;
         r_last <= 1'b0;
      end else if (r_state == S_IDLE && i_ld_start) begin
         r_ptr  <= '0;
         r_bcnt <= '0;
         r_word <= '0;
         r_last <= 1'b0;
      end else if (w_xfer) begin
         r_word <= w_word_nx;
         r_bcnt <= r_bcnt + 2'd1;
         r_last <= i_ld_last;
      end else if (r_state == S_WRITE) begin
         r_ptr  <= r_ptr + AW'(1);
         r_bcnt <= '0;
         r_word <= '0;
      end
   end

   // RAM keeps its contents across reset; no write commits on a reset edge.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         if (r_state == S_WRITE)
            r_ram[r_ptr] <= r_word;
         else if (w_cpu_we && w_is_ram)
            r_ram[w_ram_idx] <= i_tomem;
      end
   end

   // Memory-mapped registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_timer   <= '0;
         r_ovf     <= 1'b0;
         r_led     <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_timer <= w_tmr_wr ? 32'd0 : r_timer + 32'd1;
         if (w_wrap)
            r_ovf <= 1'b1;
         else if (w_cpu_we && w_is_sts && i_tomem[1])
            r_ovf <= 1'b0;
         if (w_cpu_we && w_is_led)
            r_led <= i_tomem[15:0];
         r_bus_err <= w_cpu_we &
                      ~(w_is_ram | w_is_led | w_is_tmr | w_is_sts);
      end
   end

   // Read mux
   always_comb begin
      o_frommem = '0;
      unique case (1'b1)
         w_is_ram: o_frommem = r_ram[w_ram_idx];
         w_is_led: o_frommem = {16'd0, r_led};
         w_is_tmr: o_frommem = r_timer;
         w_is_sts: o_frommem = {30'd0, r_ovf, r_state != S_IDLE};
         default:  o_frommem = '0;
      endcase
   end

   assign o_led     = r_led;
   assign o_bus_err = r_bus_err;

endmodule

// File: tb/tb_mcmem_responder.sv
// tb_mcmem_responder: directed and randomized stimulus for mcmem_responder,
// checked every cycle against a transaction-level reference model.
module tb_mcmem_responder;

   localparam int RW = 256;
   localparam logic [31:0] A_LED = 32'hFFFF_FF00;
   localparam logic [31:0] A_TMR = 32'hFFFF_FF04;
   localparam logic [31:0] A_STS = 32'hFFFF_FF08;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] madr;
   logic [31:0] tomem;
   logic        wmem;
   logic [31:0] frommem;
   logic        ld_start;
   logic        ld_valid;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        cpu_hold;
   logic        load_done;
   logic [15:0] led;
   logic        bus_err;

   always #5 clk = ~clk;

   mcmem_responder #(.RAM_WORDS(RW)) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_madr      (madr),
      .i_tomem     (tomem),
      .i_wmem      (wmem),
      .o_frommem   (frommem),
      .i_ld_start  (ld_start),
      .i_ld_valid  (ld_valid),
      .i_ld_data   (ld_data),
      .i_ld_last   (ld_last),
      .o_ld_ready  (ld_ready),
      .o_cpu_hold  (cpu_hold),
      .o_load_done (load_done),
      .o_led       (led),
      .o_bus_err   (bus_err)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int ld_done_cnt = 0;
   bit noisy = 0;
   logic [7:0] ldq[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_LOAD, M_WRITE, M_DONE} mst_t;
   mst_t        m_st = M_IDLE;
   logic [31:0] m_ram [RW];
   bit          m_known [RW];
   int          m_ptr;
   logic [7:0]  m_bytes[$];
   bit          m_last;
   logic [31:0] m_timer;
   bit          m_ovf;
   logic [15:0] m_led;
   bit          m_berr;
   bit          m_on = 0;

   // 0 RAM, 1 LED, 2 TIMER, 3 STATUS, 4 unmapped
   function automatic int cls(logic [31:0] a);
      logic [31:0] w;
      w = a & ~32'd3;
      if (a < RW * 4) return 0;
      if (w == A_LED) return 1;
      if (w == A_TMR) return 2;
      if (w == A_STS) return 3;
      return 4;
   endfunction

   function automatic logic [31:0] m_read(logic [31:0] a, output bit known);
      known = 1;
      case (cls(a))
         0: begin
            known = m_known[a / 4];
            return m_ram[a / 4];
         end
         1: return {16'd0, m_led};
         2: return m_timer;
         3: return {30'd0, m_ovf, m_st != M_IDLE};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin : model
      bit commit, set_o, clr_o;
      logic [31:0] w;
      if (rst) begin
         m_on = 1;
         m_st = M_IDLE;
         m_ptr = 0;
         m_bytes.delete();
         m_last = 0;
         m_timer = 0;
         m_ovf = 0;
         m_led = 0;
         m_berr = 0;
      end else if (m_on) begin
         commit = wmem && (m_st == M_IDLE);
         m_berr = commit && cls(madr) == 4;
         if (commit && cls(madr) == 0) begin
            m_ram[madr / 4] = tomem;
            m_known[madr / 4] = 1;
         end
         if (commit && cls(madr) == 1) m_led = tomem[15:0];
         set_o = !(commit && cls(madr) == 2) && m_timer == 32'hFFFF_FFFF;
         clr_o = commit && cls(madr) == 3 && tomem[1];
         if (set_o) m_ovf = 1;
         else if (clr_o) m_ovf = 0;
         if (commit && cls(madr) == 2) m_timer = 0;
         else m_timer = m_timer + 1;
         case (m_st)
            M_IDLE: if (ld_start) begin
               m_st = M_LOAD;
               m_ptr = 0;
               m_bytes.delete();
               m_last = 0;
            end
            M_LOAD: if (ld_valid) begin
               m_bytes.push_back(ld_data);
               m_last = ld_last;
               if (m_bytes.size() == 4 || ld_last) m_st = M_WRITE;
            end
            M_WRITE: begin
               w = 0;
               for (int i = 0; i < 4; i++)
                  w = (w << 8) | (i < m_bytes.size() ? 32'(m_bytes[i]) : 0);
               m_ram[m_ptr] = w;
               m_known[m_ptr] = 1;
               m_ptr = (m_ptr + 1) % RW;
               m_bytes.delete();
               m_st = m_last ? M_DONE : M_LOAD;
            end
            M_DONE: m_st = M_IDLE;
            default: m_st = M_IDLE;
         endcase
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin : compare
      logic [31:0] e;
      bit k;
      if (m_on) begin
         chk("ld_ready", ld_ready, m_st == M_LOAD);
         chk("cpu_hold", cpu_hold, m_st != M_IDLE);
         chk("load_done", load_done, m_st == M_DONE);
         chk("bus_err", bus_err, m_berr);
         chk("led", led, m_led);
         e = m_read(madr, k);
         if (k) chk("frommem", frommem, e);
      end
      if (load_done === 1'b1) ld_done_cnt++;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 5))
         0: return {22'd0, 8'($urandom_range(0, 7)), 2'($urandom)};
         1: return {22'd0, 8'($urandom), 2'($urandom)};
         2: return A_LED | 32'($urandom_range(0, 3));
         3: return A_TMR;
         4: return A_STS;
         default: case ($urandom_range(0, 2))
            0: return 32'h0000_0400;
            1: return 32'hFFFF_FF0C;
            default: return $urandom | 32'h8000_0000;
         endcase
      endcase
   endfunction

   task automatic cpu_write(logic [31:0] a, logic [31:0] d);
      madr = a;
      tomem = d;
      wmem = 1;
      tick();
      wmem = 0;
   endtask

   task automatic start_load();
      ld_start = 1;
      tick();
      ld_start = 0;
   endtask

   task automatic send_byte(logic [7:0] d, bit l, int gap);
      bit rdy;
      int n;
      ld_valid = 0;
      repeat (gap) tick();
      ld_valid = 1;
      ld_data = d;
      ld_last = l;
      n = 0;
      do begin
         if (noisy) begin
            wmem = ($urandom_range(0, 2) == 0);
            madr = rand_addr();
            tomem = $urandom;
            ld_start = ($urandom_range(0, 3) == 0);
         end
         #2;
         rdy = ld_ready;
         tick();
         n++;
      end while (!rdy && n < 50);
      ld_valid = 0;
      ld_last = 0;
      wmem = 0;
      ld_start = 0;
      chk("ld_handshake", rdy, 1);
   endtask

   task automatic wait_idle();
      bit h;
      int n;
      n = 0;
      do begin
         #2;
         h = cpu_hold;
         tick();
         n++;
      end while (h && n < 20);
      chk("wait_idle", h, 0);
   endtask

   task automatic load_q(int maxgap);
      start_load();
      for (int i = 0; i < ldq.size(); i++)
         send_byte(ldq[i], i == ldq.size() - 1, $urandom_range(0, maxgap));
      wait_idle();
   endtask

   initial begin
      rst = 1; wmem = 0; madr = 0; tomem = 0;
      ld_start = 0; ld_valid = 0; ld_data = 0; ld_last = 0;
      repeat (3) tick();
      rst = 0;

      // reset state
      madr = A_STS;
      #2;
      chk("rst_status", frommem, 0);
      chk("rst_led", led, 0);
      chk("rst_hold", cpu_hold, 0);
      chk("rst_ready", ld_ready, 0);
      chk("rst_berr", bus_err, 0);
      tick();
      madr = A_TMR;
      #2;
      chk("tmr_count", frommem, 1);
      tick();

      // byte load with a short final word
      ld_done_cnt = 0;
      start_load();
      send_byte(8'h12, 0, 0);
      send_byte(8'h34, 0, 0);
      send_byte(8'h56, 0, 0);
      send_byte(8'h78, 0, 0);
      send_byte(8'hAB, 1, 0);
      #2;
      chk("wr_hold", cpu_hold, 1);
      chk("wr_ready", ld_ready, 0);
      tick();
      #2;
      chk("done_pulse", load_done, 1);
      chk("done_hold", cpu_hold, 1);
      tick();
      #2;
      chk("hold_fall", cpu_hold, 0);
      chk("done_once", ld_done_cnt, 1);
      madr = 32'h0;
      #1;
      chk("ram0", frommem, 32'h1234_5678);
      madr = 32'h4;
      #1;
      chk("ram1_short", frommem, 32'hAB00_0000);
      tick();

      // CPU store, and a store ignored while held
      cpu_write(32'h10, 32'hDEAD_BEEF);
      #2;
      chk("st_rd", frommem, 32'hDEAD_BEEF);
      tick();
      start_load();
      send_byte(8'h01, 0, 0);
      cpu_write(32'h10, 32'hCAFE_F00D);
      send_byte(8'h02, 0, 0);
      send_byte(8'h03, 0, 0);
      send_byte(8'h04, 1, 0);
      wait_idle();
      madr = 32'h10;
      #2;
      chk("st_held", frommem, 32'hDEAD_BEEF);
      madr = 32'h0;
      #1;
      chk("ram0_reload", frommem, 32'h0102_0304);
      tick();

      // timer write beats the increment; overflow set beats clear
      force dut.r_timer = 32'hFFFF_FFFE;
      m_timer = 32'hFFFF_FFFE;
      #1;
      release dut.r_timer;
      madr = A_TMR;
      tomem = 32'h0;
      wmem = 1;
      tick();
      wmem = 0;
      #2;
      chk("tmr_clr", frommem, 0);
      tick();
      tick();
      madr = A_STS;
      #2;
      chk("no_ovf", frommem, 0);
      tick();
      force dut.r_timer = 32'hFFFF_FFFF;
      m_timer = 32'hFFFF_FFFF;
      #1;
      release dut.r_timer;
      madr = A_STS;
      tomem = 32'h2;
      wmem = 1;
      tick();
      wmem = 0;
      #2;
      chk("ovf_set_wins", frommem, 2);
      madr = A_TMR;
      #1;
      chk("tmr_wrap", frommem, 0);
      tick();
      cpu_write(A_STS, 32'h2);
      #2;
      chk("ovf_clr", frommem, 0);
      tick();

      // LED and unmapped write
      cpu_write(A_LED, 32'h0001_2345);
      #2;
      chk("led_out", led, 16'h2345);
      chk("led_rd", frommem, 32'h0000_2345);
      tick();
      cpu_write(32'h8000_0000, 32'h55);
      #2;
      chk("berr", bus_err, 1);
      chk("unm_rd", frommem, 0);
      chk("led_kept", led, 16'h2345);
      tick();
      #2;
      chk("berr_pulse", bus_err, 0);
      tick();

      // reset in the middle of a word
      cpu_write(32'h0, 32'h1122_3344);
      start_load();
      send_byte(8'hAA, 0, 0);
      send_byte(8'hBB, 0, 0);
      rst = 1;
      tick();
      rst = 0;
      #2;
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_ld_hold", cpu_hold, 0);
      madr = 32'h0;
      #1;
      chk("rst_keep_ram", frommem, 32'h1122_3344);
      madr = A_STS;
      #1;
      chk("rst_idle_sts", frommem, 0);
      tick();

      // 257 words into 256: pointer wraps
      ldq.delete();
      for (int k = 1; k <= 257; k++) begin
         ldq.push_back(8'hA5);
         ldq.push_back(8'h00);
         ldq.push_back(8'(k >> 8));
         ldq.push_back(8'(k));
      end
      load_q(0);
      madr = 32'h0;
      #2;
      chk("wrap_ram0", frommem, 32'hA500_0101);
      madr = 32'h4;
      #1;
      chk("wrap_ram1", frommem, 32'hA500_0002);
      madr = 32'h3FC;
      #1;
      chk("wrap_ram255", frommem, 32'hA500_0100);
      tick();

      // randomized traffic
      noisy = 1;
      for (int it = 0; it < 300; it++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op < 5) begin
            ld_valid = $urandom_range(0, 1);
            ld_data = $urandom;
            ld_last = $urandom_range(0, 1);
            cpu_write(rand_addr(), $urandom);
            madr = rand_addr();
            tick();
            ld_valid = 0;
            ld_last = 0;
         end else if (op < 8) begin
            ldq.delete();
            repeat ($urandom_range(1, 14)) ldq.push_back(8'($urandom));
            load_q(2);
         end else if (op == 8) begin
            repeat ($urandom_range(1, 4)) begin
               madr = rand_addr();
               tick();
            end
         end else begin
            start_load();
            repeat ($urandom_range(1, 6))
               send_byte(8'($urandom), 0, $urandom_range(0, 1));
            rst = 1;
            tick();
            rst = 0;
         end
      end
      noisy = 0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
